// File: rtl/gauss_pkg.sv
// Shared encodings, kernel weights and FSM state type for the strip Gaussian filter.
package gauss_pkg;

    localparam logic [1:0] MODE_BYP = 2'd0;
    localparam logic [1:0] MODE_G3  = 2'd1;
    localparam logic [1:0] MODE_G5  = 2'd2;

    localparam logic [1:0] COL_EDGE   = 2'd0;
    localparam logic [1:0] COL_INNER  = 2'd1;
    localparam logic [1:0] COL_CENTRE = 2'd2;

    localparam int unsigned RECIP_DEF = 1649;
    localparam int unsigned SHIFT_DEF = 18;

    // Indexed [column class][row].
    localparam int unsigned G5_W [3][5] = '{
        '{2, 4,  5,  4, 2},
        '{4, 9, 12,  9, 4},
        '{5, 12, 15, 12, 5}
    };
    localparam int unsigned G3_W [3][5] = '{
        '{0, 0, 0, 0, 0},
        '{0, 1, 2, 1, 0},
        '{0, 2, 4, 2, 0}
    };

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

endpackage

// File: rtl/gauss_col_mac.sv
// Weighted sum of one window column; weights are fixed per column class and built as shift-add.
module gauss_col_mac
    import gauss_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic [4:0][PIX_W-1:0] pix_i,
    input  logic [1:0]            col_class_i,
    input  logic [1:0]            mode_i,
    output logic [PIX_W+5:0]      sum_o
);

    localparam int unsigned SUM_W = PIX_W + 6;

    function automatic logic [SUM_W-1:0] mul_w(input logic [PIX_W-1:0] x, input int unsigned w);
        logic [SUM_W-1:0] acc;
        logic [3:0]       wb;
        acc = '0;
        wb  = w[3:0];
        for (int b = 0; b < 4; b++) begin
            if (wb[b]) begin
                acc = acc + (SUM_W'(x) << b);
            end
        end
        return acc;
    endfunction

    int unsigned      cls;
    logic [SUM_W-1:0] sum_g5;
    logic [SUM_W-1:0] sum_g3;

    always_comb begin
        cls = 0;
        if (col_class_i == COL_CENTRE) begin
            cls = 2;
        end else if (col_class_i == COL_INNER) begin
            cls = 1;
        end
        sum_g5 = '0;
        sum_g3 = '0;
        for (int r = 0; r < 5; r++) begin
            sum_g5 = sum_g5 + mul_w(pix_i[r], G5_W[cls][r]);
            sum_g3 = sum_g3 + mul_w(pix_i[r], G3_W[cls][r]);
        end
        sum_o = (mode_i == MODE_G3) ? sum_g3 : sum_g5;
    end

endmodule

// File: rtl/gauss_strip_filter.sv
// Strip-framed 5-column sliding-window smoother with run-time kernel select and 2-cycle latency.
module gauss_strip_filter
    import gauss_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned RECIP = RECIP_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] pix_in0,
    input  logic [PIX_W-1:0] pix_in1,
    input  logic [PIX_W-1:0] pix_in2,
    input  logic [PIX_W-1:0] pix_in3,
    input  logic [PIX_W-1:0] pix_in4,
    output logic [PIX_W-1:0] pixel_out,
    output logic             out_valid,
    output logic             out_last,
    output logic             short_err
);

    localparam int unsigned SUM_W  = PIX_W + 6;
    localparam int unsigned TOT_W  = PIX_W + 8;
    localparam int unsigned MUL_W  = TOT_W + $clog2(RECIP + 1) + 1;
    localparam int unsigned PROD_W = (MUL_W > SHIFT) ? MUL_W : SHIFT + 1;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    // Window indexed [column][row]; column 4 is the newest.
    logic [4:0][4:0][PIX_W-1:0] win_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
        end else if (in_valid) begin
            win_q <= {{pix_in4, pix_in3, pix_in2, pix_in1, pix_in0}, win_q[4:1]};
        end
    end

    state_e     state_q;
    logic [2:0] cnt_q;
    logic [1:0] mode_q;
    logic       win_vld_q;
    logic       win_last_q;
    logic       short_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mode_q      <= MODE_BYP;
            win_vld_q   <= 1'b0;
            win_last_q  <= 1'b0;
            short_err_q <= 1'b0;
        end else begin
            win_vld_q   <= 1'b0;
            win_last_q  <= 1'b0;
            short_err_q <= 1'b0;
            if (in_valid) begin
                if (in_first) begin
                    mode_q <= mode;
                    cnt_q  <= 3'd1;
                    if (in_last) begin
                        short_err_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        state_q <= StFill;
                    end
                end else begin
                    case (state_q)
                        StFill: begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd4) begin
                                win_vld_q  <= 1'b1;
                                win_last_q <= in_last;
                                state_q    <= in_last ? StIdle : StRun;
                            end else if (in_last) begin
                                short_err_q <= 1'b1;
                                state_q     <= StIdle;
                            end
                        end
                        StRun: begin
                            win_vld_q  <= 1'b1;
                            win_last_q <= in_last;
                            if (in_last) begin
                                state_q <= StIdle;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [4:0][SUM_W-1:0] col_sum;

    for (genvar c = 0; c < 5; c++) begin : g_col
        localparam logic [1:0] CLS = (c == 2) ? COL_CENTRE :
                                     ((c == 1) || (c == 3)) ? COL_INNER : COL_EDGE;
        gauss_col_mac #(
            .PIX_W(PIX_W)
        ) u_mac (
            .pix_i      (win_q[c]),
            .col_class_i(CLS),
            .mode_i     (mode_q),
            .sum_o      (col_sum[c])
        );
    end

    logic [4:0][SUM_W-1:0] s1_sum_q;
    logic [PIX_W-1:0]      s1_ctr_q;
    logic [1:0]            s1_mode_q;
    logic                  s1_vld_q;
    logic                  s1_last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sum_q  <= '0;
            s1_ctr_q  <= '0;
            s1_mode_q <= MODE_BYP;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
        end else begin
            s1_vld_q  <= win_vld_q;
            s1_last_q <= win_last_q;
            if (win_vld_q) begin
                s1_sum_q  <= col_sum;
                s1_ctr_q  <= win_q[2][2];
                s1_mode_q <= mode_q;
            end
        end
    end

    logic [TOT_W-1:0]  total;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] q5;
    logic [TOT_W-1:0]  q3;
    logic [PIX_W-1:0]  res_d;

    always_comb begin
        total = '0;
        for (int c = 0; c < 5; c++) begin
            total = total + TOT_W'(s1_sum_q[c]);
        end
        // Divide by 159 as a rounded reciprocal multiply.
        prod = PROD_W'(total) * PROD_W'(RECIP) + (PROD_W'(1) << (SHIFT - 1));
        q5   = prod >> SHIFT;
        q3   = (total + TOT_W'(8)) >> 4;
        case (s1_mode_q)
            MODE_BYP: res_d = s1_ctr_q;
            MODE_G3:  res_d = (q3 > TOT_W'(PIX_MAX)) ? PIX_MAX : q3[PIX_W-1:0];
            default:  res_d = (q5 > PROD_W'(PIX_MAX)) ? PIX_MAX : q5[PIX_W-1:0];
        endcase
    end

    logic [PIX_W-1:0] pix_q;
    logic             vld_q;
    logic             last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= s1_vld_q;
            last_q <= s1_vld_q & s1_last_q;
            if (s1_vld_q) begin
                pix_q <= res_d;
            end
        end
    end

    assign pixel_out = pix_q;
    assign out_valid = vld_q;
    assign out_last  = last_q;
    assign short_err = short_err_q;

endmodule

// File: tb/tb_gauss_strip_filter.sv
// Directed self-checking bench for gauss_strip_filter with hand-computed expectations.
module tb_gauss_strip_filter;

    localparam int unsigned PW = 8;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          in_last  = 1'b0;
    logic [1:0]    mode     = 2'd0;
    logic [PW-1:0] pix_in0  = '0;
    logic [PW-1:0] pix_in1  = '0;
    logic [PW-1:0] pix_in2  = '0;
    logic [PW-1:0] pix_in3  = '0;
    logic [PW-1:0] pix_in4  = '0;
    logic [PW-1:0] pixel_out;
    logic          out_valid;
    logic          out_last;
    logic          short_err;

    typedef struct {
        logic [PW-1:0] pix;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t outq[$];
    int    errq[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;

    gauss_strip_filter #(
        .PIX_W(PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_first (in_first),
        .in_last  (in_last),
        .mode     (mode),
        .pix_in0  (pix_in0),
        .pix_in1  (pix_in1),
        .pix_in2  (pix_in2),
        .pix_in3  (pix_in3),
        .pix_in4  (pix_in4),
        .pixel_out(pixel_out),
        .out_valid(out_valid),
        .out_last (out_last),
        .short_err(short_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) outq.push_back('{pix: pixel_out, last: out_last, cyc: cyc});
        if (short_err) errq.push_back(cyc);
    end

    function automatic logic [4:0][PW-1:0] col(input logic [PW-1:0] k, input logic [PW-1:0] mid);
        col = {k, k, mid, k, k};
    endfunction

    // Returns the clock-edge number at which this column is accepted.
    task automatic drive(input logic f, input logic l, input logic [1:0] m,
                         input logic [4:0][PW-1:0] c, output int acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        mode     = m;
        pix_in0  = c[0];
        pix_in1  = c[1];
        pix_in2  = c[2];
        pix_in3  = c[3];
        pix_in4  = c[4];
        acc      = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({pixel_out, out_valid, out_last, short_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got pix=%0d v=%0b l=%0b e=%0b, want all 0",
                     pixel_out, out_valid, out_last, short_err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_g5_uniform();
        int acc[8];
        outq.delete();
        for (int i = 0; i < 8; i++) drive(i == 0, i == 7, 2'd2, col(8'd200, 8'd200), acc[i]);
        idle(4);
        checks++;
        if (outq.size() != 4) begin
            failures++;
            $display("FAIL g5_count: got %0d beats, want 4", outq.size());
        end
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            checks++;
            if (outq[i].pix !== 8'd200 || outq[i].last !== (i == 3) || outq[i].cyc != acc[i+4] + 2)
            begin
                failures++;
                $display("FAIL g5_beat%0d: got pix=%0d last=%0b cyc=%0d, want pix=200 last=%0b cyc=%0d",
                         i, outq[i].pix, outq[i].last, outq[i].cyc, (i == 3), acc[i+4] + 2);
            end
        end
    endtask

    task automatic test_impulse();
        logic [1:0]    m;
        logic [PW-1:0] e;
        logic [PW-1:0] mid;
        int            a;
        for (int k = 0; k < 2; k++) begin
            m = (k == 0) ? 2'd2 : 2'd1;
            e = (k == 0) ? 8'd15 : 8'd40;
            outq.delete();
            for (int i = 0; i < 5; i++) begin
                mid = (i == 2) ? 8'd159 : 8'd0;
                drive(i == 0, i == 4, m, col(8'd0, mid), a);
            end
            idle(4);
            checks++;
            if (outq.size() != 1) begin
                failures++;
                $display("FAIL impulse_count mode=%0d: got %0d beats, want 1", m, outq.size());
            end else begin
                checks++;
                if (outq[0].pix !== e || outq[0].last !== 1'b1 || outq[0].cyc != a + 2) begin
                    failures++;
                    $display("FAIL impulse mode=%0d: got pix=%0d last=%0b cyc=%0d, want %0d 1 %0d",
                             m, outq[0].pix, outq[0].last, outq[0].cyc, e, a + 2);
                end
            end
        end
    endtask

    task automatic test_sat_bypass();
        logic [1:0]    m;
        logic [PW-1:0] e;
        logic [PW-1:0] k;
        logic [PW-1:0] mid;
        int            a;
        for (int t = 0; t < 2; t++) begin
            m = (t == 0) ? 2'd2 : 2'd0;
            e = (t == 0) ? 8'd255 : 8'd37;
            k = (t == 0) ? 8'd255 : 8'd90;
            outq.delete();
            for (int i = 0; i < 5; i++) begin
                mid = (t == 1 && i == 2) ? 8'd37 : k;
                drive(i == 0, i == 4, m, col(k, mid), a);
            end
            idle(4);
            checks++;
            if (outq.size() != 1) begin
                failures++;
                $display("FAIL satbyp_count mode=%0d: got %0d beats, want 1", m, outq.size());
            end else begin
                checks++;
                if (outq[0].pix !== e || outq[0].cyc != a + 2) begin
                    failures++;
                    $display("FAIL satbyp mode=%0d: got pix=%0d cyc=%0d, want pix=%0d cyc=%0d",
                             m, outq[0].pix, outq[0].cyc, e, a + 2);
                end
            end
        end
    endtask

    task automatic test_gaps();
        int            acc[6];
        logic [PW-1:0] mid;
        logic [PW-1:0] ep[2];
        ep[0] = 8'd15;
        ep[1] = 8'd12;
        outq.delete();
        for (int i = 0; i < 6; i++) begin
            mid = (i == 2) ? 8'd159 : 8'd0;
            drive(i == 0, i == 5, 2'd2, col(8'd0, mid), acc[i]);
            idle(1);
        end
        idle(4);
        checks++;
        if (outq.size() != 2) begin
            failures++;
            $display("FAIL gaps_count: got %0d beats, want 2", outq.size());
        end
        for (int i = 0; i < 2 && i < outq.size(); i++) begin
            checks++;
            if (outq[i].pix !== ep[i] || outq[i].last !== (i == 1) || outq[i].cyc != acc[i+4] + 2)
            begin
                failures++;
                $display("FAIL gaps_beat%0d: got pix=%0d last=%0b cyc=%0d, want %0d %0b %0d",
                         i, outq[i].pix, outq[i].last, outq[i].cyc, ep[i], (i == 1), acc[i+4] + 2);
            end
        end
    endtask

    task automatic test_short();
        int a;
        outq.delete();
        errq.delete();
        drive(1'b1, 1'b0, 2'd2, col(8'd9, 8'd9), a);
        drive(1'b0, 1'b0, 2'd2, col(8'd9, 8'd9), a);
        drive(1'b0, 1'b1, 2'd2, col(8'd9, 8'd9), a);
        idle(4);
        checks++;
        if (errq.size() != 1 || outq.size() != 0 || (errq.size() == 1 && errq[0] != a)) begin
            failures++;
            $display("FAIL short3: got errs=%0d outs=%0d, want errs=1 at cyc %0d outs=0",
                     errq.size(), outq.size(), a);
        end
        errq.delete();
        drive(1'b1, 1'b1, 2'd2, col(8'd9, 8'd9), a);
        idle(4);
        checks++;
        if (errq.size() != 1 || outq.size() != 0 || (errq.size() == 1 && errq[0] != a)) begin
            failures++;
            $display("FAIL short_first_last: got errs=%0d outs=%0d, want errs=1 at cyc %0d outs=0",
                     errq.size(), outq.size(), a);
        end
        errq.delete();
        for (int i = 0; i < 6; i++) drive(1'b0, i == 5, 2'd2, col(8'd77, 8'd77), a);
        idle(4);
        checks++;
        if (errq.size() != 0 || outq.size() != 0) begin
            failures++;
            $display("FAIL idle_drop: got errs=%0d outs=%0d, want 0 0", errq.size(), outq.size());
        end
    endtask

    task automatic test_restart();
        int            acc[11];
        logic [PW-1:0] mid;
        logic [PW-1:0] ep[3];
        int            ec[3];
        outq.delete();
        errq.delete();
        for (int i = 0; i < 6; i++) drive(i == 0, 1'b0, 2'd2, col(8'd100, 8'd100), acc[i]);
        for (int i = 6; i < 11; i++) begin
            mid = (i == 8) ? 8'd159 : 8'd0;
            drive(i == 6, i == 10, 2'd1, col(8'd0, mid), acc[i]);
        end
        idle(4);
        ep[0] = 8'd100;
        ep[1] = 8'd100;
        ep[2] = 8'd40;
        ec[0] = acc[4] + 2;
        ec[1] = acc[5] + 2;
        ec[2] = acc[10] + 2;
        checks++;
        if (outq.size() != 3 || errq.size() != 0) begin
            failures++;
            $display("FAIL restart_count: got %0d beats %0d errs, want 3 beats 0 errs",
                     outq.size(), errq.size());
        end
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            checks++;
            if (outq[i].pix !== ep[i] || outq[i].last !== (i == 2) || outq[i].cyc != ec[i]) begin
                failures++;
                $display("FAIL restart_beat%0d: got pix=%0d last=%0b cyc=%0d, want %0d %0b %0d",
                         i, outq[i].pix, outq[i].last, outq[i].cyc, ep[i], (i == 2), ec[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int a;
        for (int i = 0; i < 7; i++) drive(i == 0, 1'b0, 2'd2, col(8'd200, 8'd200), a);
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b1 || pixel_out !== 8'd200) begin
            failures++;
            $display("FAIL pre_reset_run: got v=%0b pix=%0d, want v=1 pix=200", out_valid, pixel_out);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checks++;
        if ({pixel_out, out_valid, out_last, short_err} !== '0) begin
            failures++;
            $display("FAIL async_reset: got pix=%0d v=%0b l=%0b e=%0b, want all 0",
                     pixel_out, out_valid, out_last, short_err);
        end
        @(negedge clk);
        reset = 1'b0;
        outq.delete();
        errq.delete();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'd2, col(8'd200, 8'd200), a);
        idle(4);
        checks++;
        if (outq.size() != 0) begin
            failures++;
            $display("FAIL post_reset_quiet: got %0d beats, want 0", outq.size());
        end
        for (int i = 0; i < 5; i++) drive(i == 0, i == 4, 2'd2, col(8'd60, 8'd60), a);
        idle(4);
        checks++;
        if (outq.size() != 1) begin
            failures++;
            $display("FAIL post_reset_count: got %0d beats, want 1", outq.size());
        end else begin
            checks++;
            if (outq[0].pix !== 8'd60 || outq[0].last !== 1'b1 || outq[0].cyc != a + 2) begin
                failures++;
                $display("FAIL post_reset_beat: got pix=%0d last=%0b cyc=%0d, want 60 1 %0d",
                         outq[0].pix, outq[0].last, outq[0].cyc, a + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_g5_uniform();
        test_impulse();
        test_sat_bypass();
        test_gaps();
        test_short();
        test_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
